// File: rtl/fir_mac_serial_if.sv
// Handshake and coefficient-write bundle for the serial FIR MAC.
// slave is the filter side; master is the side that feeds samples and
// writes coefficients.
interface fir_mac_serial_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 64,
   parameter int ADDR_W = 5
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     coef_we;
   logic [ADDR_W-1:0]        coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic                     out_valid;
   logic signed [ACC_W-1:0]  out_data;
   logic                     busy;

   modport slave (
      input  in_valid,
      input  in_data,
      input  coef_we,
      input  coef_addr,
      input  coef_wdata,
      output in_ready,
      output out_valid,
      output out_data,
      output busy
   );

   modport master (
      output in_valid,
      output in_data,
      output coef_we,
      output coef_addr,
      output coef_wdata,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  busy
   );
endinterface

// File: rtl/fir_mac_serial.sv
// Time-multiplexed signed FIR: one multiply-accumulate per clock over all
// taps, producing y[n] = sum h[k]*x[n-k] for the downstream error stage.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a sample; coefficient writes accepted here only
// MAC   | sweeping taps 0..TAPS-1, one product accumulated per cycle
// DONE  | sweep finished; result registered to out_data on leaving
module fir_mac_serial #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 32,
   parameter int ACC_W  = 64,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   fir_mac_serial_if.slave     bus
);
   localparam int                PROD_W   = DATA_W + COEF_W;
   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state_q;
   state_t                    state_d;

   logic signed [DATA_W-1:0]  x_q [TAPS];
   logic signed [COEF_W-1:0]  h_q [TAPS];
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   out_data_q;
   logic                      out_valid_q;
   logic                      up_q;
   logic [ADDR_W-1:0]         tap_q;

   logic                      accept;
   logic                      mac_en;
   logic                      in_ready_c;
   logic                      busy_c;
   logic                      last_tap;
   logic                      coef_ok;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;

   assign last_tap = (tap_q == LAST_TAP);

   // Full-width signed product; the size casts sign-extend both operands so
   // the multiply is done at PROD_W rather than truncated to operand width.
   assign prod     = PROD_W'(x_q[tap_q]) * PROD_W'(h_q[tap_q]);
   assign prod_ext = ACC_W'(prod);

   // Writes land only between sweeps so a running sum never sees a mix of
   // old and new coefficients; out-of-range addresses are dropped.
   assign coef_ok  = bus.coef_we && (state_q == IDLE) && (int'(bus.coef_addr) < TAPS);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and per-state control strobes.
   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      busy_c     = 1'b0;
      accept     = 1'b0;
      mac_en     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = up_q;
            accept     = up_q && bus.in_valid;
            if (accept) state_d = MAC;
         end
         MAC: begin
            busy_c = 1'b1;
            mac_en = 1'b1;
            if (last_tap) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holds in_ready low for the cycle following reset release.
   always_ff @(posedge clk) begin
      if (rst) up_q <= 1'b0;
      else     up_q <= 1'b1;
   end

   // Sample delay line: x[0] is the newest sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      end else if (accept) begin
         x_q[0] <= bus.in_data;
         for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
   end

   // Coefficient bank; cleared by reset along with everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
      end else if (coef_ok) begin
         h_q[bus.coef_addr] <= bus.coef_wdata;
      end
   end

   // Accumulator and tap index; both restart on every accepted sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         tap_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
         tap_q <= '0;
      end else if (mac_en) begin
         acc_q <= acc_q + prod_ext;
         tap_q <= tap_q + ADDR_W'(1);
      end
   end

   // Result register and single-cycle valid pulse on leaving DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= (state_q == DONE);
         if (state_q == DONE) out_data_q <= acc_q;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fir_mac_serial.sv
// Self-checking bench for fir_mac_serial: a cycle-level reference model
// predicts in_ready/busy/out_valid/out_data; expected results are queued at
// accept and popped when the output is due.
module tb_fir_mac_serial;
   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int TAPS   = 32;
   localparam int ACC_W  = 64;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fir_mac_serial_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

   fir_mac_serial #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint y;
      longint t;
   } exp_t;

   exp_t   sb [$];
   int     n_err = 0;
   int     n_chk = 0;
   longint edge_cnt = 0;
   longint m_h [TAPS];
   longint m_x [TAPS];
   longint m_out = 0;
   longint last_y = 0;
   longint idle_from = 0;
   longint last_acc_m = -1000;
   longint acc_edge = 0;
   bit     m_up = 0;
   bit     armed = 0;
   int     ov_cnt = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Edge counter used to time accepts and outputs.
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Reference model: checks the current cycle, then predicts the next edge.
   always @(negedge clk) begin
      bit     exp_ready;
      bit     exp_busy;
      bit     exp_ov;
      longint y;
      exp_ready = m_up && (edge_cnt >= idle_from);
      exp_busy  = (edge_cnt >= last_acc_m) && (edge_cnt < last_acc_m + TAPS);
      // out_valid is due in the cycle after edge accept+TAPS+1, i.e. it is
      // sampled high by the consumer at edge accept+TAPS+2.
      exp_ov    = (sb.size() != 0) && (edge_cnt == sb[0].t + TAPS + 1);
      if (bus.out_valid) ov_cnt++;
      if (armed) begin
         chk("in_ready", bus.in_ready, exp_ready);
         chk("busy", bus.busy, exp_busy);
         chk("out_valid", bus.out_valid, exp_ov);
         if (exp_ov) begin
            exp_t e;
            e = sb.pop_front();
            m_out  = e.y;
            last_y = e.y;
         end
         chk("out_data", bus.out_data, m_out);
      end
      if (rst) begin
         armed      = 1;
         m_up       = 0;
         idle_from  = 0;
         last_acc_m = -1000;
         m_out      = 0;
         sb.delete();
         for (int k = 0; k < TAPS; k++) begin
            m_h[k] = 0;
            m_x[k] = 0;
         end
      end else begin
         if (bus.coef_we && edge_cnt >= idle_from && int'(bus.coef_addr) < TAPS)
            m_h[bus.coef_addr] = longint'(bus.coef_wdata);
         if (bus.in_valid && exp_ready) begin
            for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = longint'(bus.in_data);
            y = 0;
            for (int k = 0; k < TAPS; k++) y += m_h[k] * m_x[k];
            sb.push_back('{y: y, t: edge_cnt + 1});
            last_acc_m = edge_cnt + 1;
            idle_from  = edge_cnt + 1 + TAPS + 1;
         end
         m_up = 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   task automatic wr_coef(input int a, input longint v);
      bus.coef_we    = 1'b1;
      bus.coef_addr  = ADDR_W'(a);
      bus.coef_wdata = COEF_W'(v);
      step(1);
      bus.coef_we    = 1'b0;
   endtask

   // Presents a sample until accepted; keep leaves in_valid asserted.
   task automatic send(input longint s, input bit keep);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(s);
      @(negedge clk);
      while (!bus.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", n >= 300, 0);
      acc_edge = edge_cnt + 1;
      step(1);
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         step(1);
         n++;
      end
      chk("drain_timeout", n >= 500, 0);
      step(1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      longint prev_acc;
      int     snap;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.coef_we    = 1'b0;
      bus.coef_addr  = '0;
      bus.coef_wdata = '0;

      // Reset state.
      do_reset();
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_valid", bus.out_valid, 0);

      // Impulse response with h[k] = k+1.
      for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
      send(1000, 0);
      for (int k = 1; k < TAPS; k++) send(0, 0);
      wait_done();
      chk("impulse_last", last_y, 32000);

      // Full-scale negative coefficients and samples.
      for (int k = 0; k < TAPS; k++) wr_coef(k, -32768);
      for (int k = 0; k < TAPS; k++) send(-32768, 0);
      wait_done();
      chk("fullscale_neg", last_y, 64'sd34359738368);

      // Mixed sign from a clean delay line.
      do_reset();
      wr_coef(0, 3);
      wr_coef(1, -2);
      send(5, 0);
      wait_done();
      chk("mixed_first", last_y, 15);
      send(-7, 0);
      wait_done();
      chk("mixed_second", last_y, -31);

      // Write during MAC must be ignored.
      send(1, 0);
      step(3);
      wr_coef(0, 100);
      wait_done();
      chk("busy_wr_sweep", last_y, 17);
      send(2, 0);
      wait_done();
      chk("busy_wr_next", last_y, 4);

      // Write together with accept: the new coefficient is used right away.
      bus.coef_we    = 1'b1;
      bus.coef_addr  = ADDR_W'(0);
      bus.coef_wdata = COEF_W'(10);
      send(3, 0);
      bus.coef_we    = 1'b0;
      wait_done();
      chk("same_edge_wr", last_y, 26);

      // Reset at MAC cycle 10: sweep aborted, coefficients cleared.
      snap = ov_cnt;
      send(5, 0);
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("abort_out_data", bus.out_data, 0);
      @(negedge clk);
      chk("abort_ready_low", bus.in_ready, 0);
      @(negedge clk);
      chk("abort_ready_high", bus.in_ready, 1);
      step(1);
      last_y = 77;
      send(1000, 0);
      wait_done();
      chk("abort_impulse", last_y, 0);
      chk("abort_pulses", ov_cnt - snap, 1);

      // Back-pressure: in_valid held high across a ramp.
      wr_coef(0, 1);
      prev_acc = 0;
      for (int k = 1; k <= 8; k++) begin
         send(k, k != 8);
         if (k > 1) chk("bp_spacing", acc_edge - prev_acc, TAPS + 2);
         prev_acc = acc_edge;
      end
      wait_done();
      chk("bp_last", last_y, 8);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
- Time-multiplexed signed FIR filter; one multiply-accumulate per clock over TAPS coefficients.
- Produces the 64-bit signed filter estimate y[n] that feeds the error subtractor as its subtrahend: error = desired - y.
- Coefficients are written by the adaptation logic or host.
- Sits between the ADC sample path and the 64-bit error stage of the noise-cancelling loop.

Parameters:
- DATA_W, 16, signed sample width.
- COEF_W, 16, signed coefficient width.
- TAPS, 32, filter length; must be at least 2.
- ACC_W, 64, accumulator and output width.
- ADDR_W, 5, coefficient address width; equals clog2(TAPS).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_W  signed input sample x[n].
- coef_we  input  1  coefficient write strobe.
- coef_addr  input  ADDR_W  tap index to write.
- coef_wdata  input  COEF_W  signed coefficient value.
- out_valid  output  1  one-cycle pulse; out_data is a new result.
- out_data  output  ACC_W  signed y[n] = sum over k of h[k]*x[n-k].
- busy  output  1  high while a MAC sweep is in progress.

Behaviour:
- Reset (rst high at a clock edge):
  - Delay line x[0..TAPS-1] = 0, coefficients h[] = 0, accumulator = 0.
  - out_data = 0, out_valid = 0, busy = 0, in_ready = 0, state = IDLE.
  - in_ready goes to 1 on the first edge after rst deasserts.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: delay line shifts (x[0] <= in_data, x[k] <= x[k-1]); accumulator cleared; tap index i = 0; go to MAC.
- MAC:
  - in_ready = 0, busy = 1.
  - Each cycle: acc <= acc + sext(x[i]*h[i]); the product is a full DATA_W+COEF_W signed value, sign-extended to ACC_W.
  - i increments each cycle; after the i = TAPS-1 cycle, go to DONE.
- DONE:
  - out_data <= acc; out_valid = 1 for exactly this one cycle; return to IDLE.
  - in_ready is 0 in DONE.
- Latency: sample accepted at edge T; out_valid is high in the cycle after edge T+TAPS+1.
- Throughput: one sample per TAPS+2 cycles.
- out_data holds its value until the next DONE.
- Arithmetic:
  - Two's complement throughout.
  - With the defaults, worst case is 32 * 2^30 < 2^63, so no overflow is possible.
  - For other parameter sets the accumulator wraps modulo 2^ACC_W; no saturation.
- Coefficient writes:
  - Honoured only when state = IDLE and coef_addr < TAPS.
  - Ignored otherwise, with no side effects.
  - A write takes effect at the clock edge of the strobe.
  - Simultaneous accept and coef write in IDLE: the new coefficient is used by the sweep that starts on that edge.
- in_valid while in_ready = 0: the sample is not consumed and the delay line is unchanged; the upstream holds the sample.
- rst during MAC or DONE: sweep aborted, no out_valid pulse, every register returns to its reset value, including coefficients.
- out_valid never asserts for two consecutive cycles.

Test Plan:
- Impulse response: after reset, write h[k] = k+1 for k = 0..31; feed 1000, then 31 zeros -> outputs 1000, 2000, ..., 32000, each out_valid exactly TAPS+2 cycles after its accept.
- Full-scale negative: h[all] = -32768; feed 32 samples of -32768 -> 32nd output = 34359738368 (0x0000_0008_0000_0000); no sign error.
- Mixed sign: h[0] = 3, h[1] = -2, others 0; feed 5 then -7 -> outputs 15, then -21-10 = -31 (0xFFFF_FFFF_FFFF_FFE1).
- Busy write rejected: during MAC write h[0] = 100 -> ignored; the next result uses the old h[0]; a write with coef_addr >= TAPS is ignored.
- Reset mid-sweep: assert rst at MAC cycle 10 -> no out_valid; out_data = 0; in_ready = 1 one cycle after release; a subsequent impulse reproduces the h[] = 0 result (0).
- Back-pressure: hold in_valid high continuously -> a sample is accepted every 34 cycles; no sample lost or duplicated (check with a 1, 2, 3, ... ramp).
